// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter
// Shares the write port of an external FIFO between two producers using
// round-robin arbitration with bounded bursts, and gates the consumer's read
// port. Occupancy is tracked locally, so no write is issued into a full FIFO
// and no read is issued from an empty one. All strobes and write data toward
// the FIFO are registered; grants back to the producers/consumer are
// combinational and mean "accepted at this edge".
module fifo_write_arbiter #(
  parameter int DW    = 8,   // data width
  parameter int DEPTH = 16,  // FIFO depth in words, must match the attached FIFO
  parameter int CW    = 5,   // count width, 2**CW > DEPTH
  parameter int BURST = 4    // max words per grant window, >= 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic [DW-1:0] data0,
  input  logic [DW-1:0] data1,
  output logic          gnt0,
  output logic          gnt1,
  input  logic          rd_req,
  output logic          rd_gnt,
  output logic          fifo_wr_cs,
  output logic          fifo_rd_cs,
  output logic [DW-1:0] fifo_data,
  input  logic          fifo_overflow,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          err
);

  // Burst counter width; a single-word burst still needs a 1-bit counter.
  localparam int            BW      = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [BW-1:0] BLAST   = BW'(BURST - 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SERVE0 = 2'd1,
    SERVE1 = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic          last, last_nxt;   // source served most recently; 1 -> src0 wins a tie
  logic [BW-1:0] bcnt, bcnt_nxt;   // words accepted in the current burst
  logic          wr_acc;

  // Occupancy flags and grants; a grant already implies its request.
  assign full   = (count == DEPTH_C);
  assign empty  = (count == '0);
  assign gnt0   = (state == SERVE0) & req0 & ~full;
  assign gnt1   = (state == SERVE1) & req1 & ~full;
  assign rd_gnt = rd_req & ~empty;
  assign wr_acc = gnt0 | gnt1;

  // Next-state logic: round-robin selection from IDLE, burst bookkeeping in SERVEn.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    state_nxt = state;
    last_nxt  = last;
    bcnt_nxt  = bcnt;
    unique case (state)
      IDLE: begin
        if (req0 && req1) state_nxt = last ? SERVE0 : SERVE1;
        else if (req0)    state_nxt = SERVE0;
        else if (req1)    state_nxt = SERVE1;
      end
      SERVE0: begin
        if (!req0) begin
          // Source withdrew: hand over to the other one or fall back to IDLE.
          state_nxt = req1 ? SERVE1 : IDLE;
          bcnt_nxt  = '0;
          last_nxt  = 1'b0;
        end else if (gnt0) begin
          if (bcnt == BLAST) begin
            // Burst expired: yield if the other source waits, else restart.
            bcnt_nxt = '0;
            if (req1) begin
              state_nxt = SERVE1;
              last_nxt  = 1'b0;
            end
          end else begin
            bcnt_nxt = bcnt + BW'(1);
          end
        end
        // Requesting but full: hold state and burst count.
      end
      SERVE1: begin
        if (!req1) begin
          state_nxt = req0 ? SERVE0 : IDLE;
          bcnt_nxt  = '0;
          last_nxt  = 1'b1;
        end else if (gnt1) begin
          if (bcnt == BLAST) begin
            bcnt_nxt = '0;
            if (req0) begin
              state_nxt = SERVE0;
              last_nxt  = 1'b1;
            end
          end else begin
            bcnt_nxt = bcnt + BW'(1);
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        bcnt_nxt  = '0;
      end
    endcase
  end

  // Arbiter state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state <= IDLE;
      last  <= 1'b1;
      bcnt  <= '0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      bcnt  <= bcnt_nxt;
    end
  end

  // FIFO strobes, write data, occupancy counter and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_wr_cs <= 1'b0;
      fifo_rd_cs <= 1'b0;
      fifo_data  <= '0;
      count      <= '0;
      err        <= 1'b0;
    end else begin
      fifo_wr_cs <= wr_acc;
      fifo_rd_cs <= rd_gnt;
      if (gnt0)      fifo_data <= data0;
      else if (gnt1) fifo_data <= data1;
      // Grants are already masked by full/empty, so count cannot wrap.
      unique case ({wr_acc, rd_gnt})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (fifo_overflow) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter
// Randomized stimulus in phases (fill, mixed, drain, saturation, resets)
// compared every cycle against a rule-level reference model.
module tb_fifo_write_arbiter;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int CW    = 5;
  localparam int BURST = 4;

  logic          clk = 1'b0;
  logic          rst, req0, req1, rd_req, fifo_overflow;
  logic [DW-1:0] data0, data1, fifo_data;
  logic          gnt0, gnt1, rd_gnt, fifo_wr_cs, fifo_rd_cs, full, empty, err;
  logic [CW-1:0] count;

  fifo_write_arbiter #(.DW(DW), .DEPTH(DEPTH), .CW(CW), .BURST(BURST)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .data0(data0), .data1(data1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rd_req(rd_req), .rd_gnt(rd_gnt),
    .fifo_wr_cs(fifo_wr_cs), .fifo_rd_cs(fifo_rd_cs), .fifo_data(fifo_data),
    .fifo_overflow(fifo_overflow),
    .count(count), .full(full), .empty(empty), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: which source is being served (-1 none), words taken in
  // the current window, who was served last, and the word count.
  int srv, used, last, cnt;
  int m_wr, m_rd, m_err, m_data;

  function automatic void model_reset();
    srv = -1; used = 0; last = 1; cnt = 0;
    m_wr = 0; m_rd = 0; m_err = 0; m_data = 0;
  endfunction

  // One cycle: drive inputs after the falling edge, check outputs, then
  // advance the model to what the next rising edge should produce.
  task automatic step(input bit r, input bit q0, input bit q1, input bit rr, input bit ov);
    int g0, g1, rg, n, rn, ro;
    @(negedge clk);
    rst = r; req0 = q0; req1 = q1; rd_req = rr; fifo_overflow = ov;
    data0 = DW'($urandom); data1 = DW'($urandom);
    #1;
    g0 = (srv == 0 && q0 && cnt < DEPTH) ? 1 : 0;
    g1 = (srv == 1 && q1 && cnt < DEPTH) ? 1 : 0;
    rg = (rr && cnt > 0) ? 1 : 0;
    check("gnt0",   32'(gnt0),       g0);
    check("gnt1",   32'(gnt1),       g1);
    check("rd_gnt", 32'(rd_gnt),     rg);
    check("count",  32'(count),      cnt);
    check("full",   32'(full),       (cnt == DEPTH) ? 1 : 0);
    check("empty",  32'(empty),      (cnt == 0) ? 1 : 0);
    check("wr_cs",  32'(fifo_wr_cs), m_wr);
    check("rd_cs",  32'(fifo_rd_cs), m_rd);
    check("data",   32'(fifo_data),  m_data);
    check("err",    32'(err),        m_err);
    if (r) begin
      model_reset();
    end else begin
      m_wr = g0 | g1;
      if (g0 != 0)      m_data = int'(data0);
      else if (g1 != 0) m_data = int'(data1);
      m_rd = rg;
      cnt  = cnt + m_wr - rg;
      if (ov) m_err = 1;
      if (srv < 0) begin
        if (q0 && q1) srv = (last == 0) ? 1 : 0;
        else if (q0)  srv = 0;
        else if (q1)  srv = 1;
        used = 0;
      end else begin
        n  = srv;
        rn = (n == 0) ? int'(q0) : int'(q1);
        ro = (n == 0) ? int'(q1) : int'(q0);
        if (rn == 0) begin
          srv  = (ro != 0) ? 1 - n : -1;
          used = 0;
          last = n;
        end else if (g0 != 0 || g1 != 0) begin
          used++;
          if (used == BURST) begin
            used = 0;
            if (ro != 0) begin
              srv  = 1 - n;
              last = n;
            end
          end
        end
      end
    end
  endtask

  // Phase table: request / read / reset / overflow probabilities in percent.
  typedef struct {
    int p0, p1, prd, prst, pov, cycles;
  } phase_t;

  phase_t phases[$] = '{
    '{ 95,   0,   0, 0, 0,  40},   // single source fills to full
    '{ 90,  90,   0, 0, 0,  60},   // both sources, blocked at full
    '{ 90,  90,  50, 0, 0, 300},   // mixed traffic
    '{100, 100, 100, 0, 0, 200},   // both continuously, simultaneous rd/wr
    '{ 50,  20,  90, 1, 1, 300},   // drain with occasional reset/overflow
    '{ 30,  70,  40, 2, 2, 300},   // sporadic resets mid-burst
    '{  0,   0,  80, 0, 0,  40},   // drain to empty, reads while empty
    '{ 60,  60,  30, 0, 0, 300}
  };

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; rd_req = 1'b0; fifo_overflow = 1'b0;
    data0 = '0; data1 = '0;
    model_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    foreach (phases[k]) begin
      for (int c = 0; c < phases[k].cycles; c++) begin
        step($urandom_range(0, 99) < phases[k].prst,
             $urandom_range(0, 99) < phases[k].p0,
             $urandom_range(0, 99) < phases[k].p1,
             $urandom_range(0, 99) < phases[k].prd,
             $urandom_range(0, 99) < phases[k].pov);
      end
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
